// File: rtl/sysarr_psum_collector_if.sv
// rtl/sysarr_psum_collector_if.sv - stream, output FIFO and flag signals of the partial-sum collector
// The master side is the array/consumer pair; the slave side is the collector itself.
interface sysarr_psum_collector_if #(
  parameter int N              = 16,
  parameter int PARTIAL_SUM_BW = 19,
  parameter int ACC_BW         = 32,
  parameter int ROWS           = 16
);
  localparam int RW = $clog2(ROWS);

  logic                      in_valid;
  logic                      in_first;
  logic                      in_last;
  logic [N*PARTIAL_SUM_BW-1:0] psum_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [N*ACC_BW-1:0]       out_data;
  logic [RW-1:0]             out_row;
  logic                      sat_flag;
  logic                      ovf_flag;
  logic                      flag_clr;

  modport master (
    output in_valid, in_first, in_last, psum_in, out_ready, flag_clr,
    input  out_valid, out_data, out_row, sat_flag, ovf_flag
  );

  modport slave (
    input  in_valid, in_first, in_last, psum_in, out_ready, flag_clr,
    output out_valid, out_data, out_row, sat_flag, ovf_flag
  );
endinterface

// File: rtl/sysarr_psum_collector.sv
// rtl/sysarr_psum_collector.sv - de-skews PE column partial sums, accumulates rows over K passes, emits finished rows
// Lane k waits N-1-k cycles so every lane lines up with lane N-1; one registered stage later the row is accumulated.
module sysarr_psum_collector #(
  parameter int N              = 16,
  parameter int PARTIAL_SUM_BW = 19,
  parameter int ACC_BW         = 32,
  parameter int ROWS           = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input logic                    clk,
  input logic                    rstn,
  sysarr_psum_collector_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int FW = $clog2(FIFO_DEPTH);

  typedef logic [N-1:0][PARTIAL_SUM_BW-1:0] psum_vec_t;
  typedef logic [N-1:0][ACC_BW-1:0]         acc_vec_t;
  typedef logic signed [ACC_BW-1:0]         acc_t;

  localparam logic [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
  localparam logic [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

  psum_vec_t  lane_in;
  psum_vec_t  skew_q [N-1];
  logic [2:0] ctl_q  [N-1];
  logic [2:0] ctl_in;
  psum_vec_t  aligned;
  logic       av, af, al;

  always_comb begin
    lane_in = '0;
    for (int k = 0; k < N; k++) begin
      lane_in[k] = bus.psum_in[k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
    end
  end

  assign ctl_in = {bus.in_valid, bus.in_valid & bus.in_first, bus.in_valid & bus.in_last};

  // Stage j forwards stage j-1 but reloads lane j from the input, so lane k sees N-1-k registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < N-1; j++) begin
        skew_q[j] <= '0;
        ctl_q[j]  <= '0;
      end
    end else begin
      skew_q[0] <= lane_in;
      ctl_q[0]  <= ctl_in;
      for (int j = 1; j < N-1; j++) begin
        skew_q[j]    <= skew_q[j-1];
        skew_q[j][j] <= lane_in[j];
        ctl_q[j]     <= ctl_q[j-1];
      end
    end
  end

  always_comb begin
    aligned      = skew_q[N-2];
    aligned[N-1] = lane_in[N-1];
  end

  assign av = ctl_q[N-2][2];
  assign af = ctl_q[N-2][1];
  assign al = ctl_q[N-2][0];

  logic [RW-1:0] row_q, row_d;
  logic          s_valid_q, s_first_q, s_last_q;
  logic [RW-1:0] s_row_q;
  psum_vec_t     s_vec_q;

  assign row_d = av ? row_q + RW'(1) : row_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q     <= '0;
      s_valid_q <= 1'b0;
      s_first_q <= 1'b0;
      s_last_q  <= 1'b0;
      s_row_q   <= '0;
      s_vec_q   <= '0;
    end else begin
      row_q     <= row_d;
      s_valid_q <= av;
      s_first_q <= af;
      s_last_q  <= al;
      s_row_q   <= row_q;
      s_vec_q   <= aligned;
    end
  end

  acc_vec_t                acc_q [ROWS];
  acc_vec_t                acc_new;
  acc_t                    ext;
  logic [ACC_BW-1:0]       old;
  logic signed [ACC_BW:0]  sum;
  logic                    sat_hit;

  always_comb begin
    acc_new = '0;
    ext     = '0;
    old     = '0;
    sum     = '0;
    sat_hit = 1'b0;
    for (int k = 0; k < N; k++) begin
      ext = acc_t'($signed(s_vec_q[k]));
      old = acc_q[s_row_q][k];
      sum = {old[ACC_BW-1], old} + {ext[ACC_BW-1], ext};
      if (s_first_q) begin
        acc_new[k] = ext;
      end else if (sum[ACC_BW] != sum[ACC_BW-1]) begin
        acc_new[k] = sum[ACC_BW] ? ACC_MIN : ACC_MAX;
        sat_hit    = s_valid_q;
      end else begin
        acc_new[k] = sum[ACC_BW-1:0];
      end
    end
  end

  // Accumulators carry no reset: the first pass after reset overwrites every row it touches.
  always_ff @(posedge clk) begin
    if (s_valid_q) begin
      acc_q[s_row_q] <= acc_new;
    end
  end

  acc_vec_t      fdata_q [FIFO_DEPTH];
  logic [RW-1:0] frow_q  [FIFO_DEPTH];
  logic [FW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          empty, full, push_req, push, pop, drop;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[FW] != rd_q[FW]) && (wr_q[FW-1:0] == rd_q[FW-1:0]);
  assign push_req = s_valid_q & s_last_q;
  assign pop      = !empty & bus.out_ready;
  assign push     = push_req & (!full | pop);
  assign drop     = push_req & full & !pop;

  assign wr_d = push ? wr_q + {{FW{1'b0}}, 1'b1} : wr_q;
  assign rd_d = pop  ? rd_q + {{FW{1'b0}}, 1'b1} : rd_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fdata_q[wr_q[FW-1:0]] <= acc_new;
      frow_q[wr_q[FW-1:0]]  <= s_row_q;
    end
  end

  logic sat_q, sat_d, ovf_q, ovf_d;

  // A set event in the same cycle as flag_clr keeps the flag high.
  assign sat_d = sat_hit | (sat_q & ~bus.flag_clr);
  assign ovf_d = drop    | (ovf_q & ~bus.flag_clr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : fdata_q[rd_q[FW-1:0]];
  assign bus.out_row   = empty ? '0 : frow_q[rd_q[FW-1:0]];
  assign bus.sat_flag  = sat_q;
  assign bus.ovf_flag  = ovf_q;
endmodule

// File: tb/tb_sysarr_psum_collector.sv
// tb/tb_sysarr_psum_collector.sv - self-checking bench for sysarr_psum_collector
// A queue-based model tracks accumulators, FIFO contents and flags; tables hold fixed expectations.
module tb_sysarr_psum_collector;
  localparam int N    = 4;
  localparam int PSB  = 19;
  localparam int ACC  = 20;
  localparam int ROWS = 4;
  localparam int FD   = 4;
  localparam int DW   = N * ACC;
  localparam longint AMAX = (64'sd1 <<< (ACC-1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (ACC-1));

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sysarr_psum_collector_if #(.N(N), .PARTIAL_SUM_BW(PSB), .ACC_BW(ACC), .ROWS(ROWS)) bus ();

  sysarr_psum_collector #(
    .N(N), .PARTIAL_SUM_BW(PSB), .ACC_BW(ACC), .ROWS(ROWS), .FIFO_DEPTH(FD)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct { bit v; bit f; bit l; int lane [N]; } beat_t;
  typedef struct { int row; logic [DW-1:0] data; } ent_t;
  typedef struct { int due; bit l; bit sat; ent_t e; } pend_t;
  typedef struct { int base; int exp_row; logic [DW-1:0] exp_data; } skew_vec_t;
  typedef struct { int val; bit first; bit last; int exp; } pass_vec_t;

  beat_t  hist [N];
  pend_t  pend [$];
  ent_t   mq   [$];
  ent_t   got  [$];
  longint macc [ROWS][N];
  int     mrow;
  bit     msat, movf;
  int     ecount;
  int     checks, errors;
  ent_t   last_obs;
  int     first_ov_e;

  skew_vec_t skew_tab [ROWS];
  pass_vec_t pass_tab [4];

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [ACC-1:0] lane_bits(longint v);
    return v[ACC-1:0];
  endfunction

  function automatic void check_lanes(string name, logic [DW-1:0] d, longint base, longint stp);
    for (int k = 0; k < N; k++) check(name, d[k*ACC +: ACC], lane_bits(base + stp * k));
  endfunction

  function automatic beat_t mk(bit v, bit f, bit l, int base, int stp);
    beat_t b;
    b.v = v; b.f = f; b.l = l;
    for (int k = 0; k < N; k++) b.lane[k] = base + stp * k;
    return b;
  endfunction

  function automatic void model_issue(beat_t b);
    pend_t p;
    longint t;
    p.sat = 1'b0;
    p.e.data = '0;
    for (int k = 0; k < N; k++) begin
      t = b.f ? longint'(b.lane[k]) : macc[mrow][k] + longint'(b.lane[k]);
      if (t > AMAX) begin t = AMAX; p.sat = 1'b1; end
      if (t < AMIN) begin t = AMIN; p.sat = 1'b1; end
      macc[mrow][k] = t;
      p.e.data[k*ACC +: ACC] = t[ACC-1:0];
    end
    p.e.row = mrow;
    p.due = ecount + N;
    p.l = b.l;
    pend.push_back(p);
    mrow = (mrow + 1) % ROWS;
  endfunction

  function automatic void model_edge(bit rdy, bit clr);
    pend_t p;
    bit sat_ev = 1'b0;
    bit drop_ev = 1'b0;
    if (mq.size() > 0 && rdy) begin
      void'(mq.pop_front());
      got.push_back(last_obs);
    end
    if (pend.size() > 0 && pend[0].due == ecount) begin
      p = pend.pop_front();
      sat_ev = p.sat;
      if (p.l) begin
        if (mq.size() < FD) mq.push_back(p.e);
        else drop_ev = 1'b1;
      end
    end
    msat = sat_ev  | (msat & !clr);
    movf = drop_ev | (movf & !clr);
  endfunction

  function automatic void model_reset();
    pend.delete();
    mq.delete();
    mrow = 0;
    msat = 1'b0;
    movf = 1'b0;
    for (int i = 0; i < N; i++) hist[i] = mk(0, 0, 0, 0, 0);
  endfunction

  function automatic void compare();
    check("out_valid", bus.out_valid, mq.size() > 0);
    if (mq.size() > 0 && bus.out_valid) begin
      check("out_row", bus.out_row, mq[0].row);
      check("out_data", bus.out_data, mq[0].data);
    end
    check("sat_flag", bus.sat_flag, msat);
    check("ovf_flag", bus.ovf_flag, movf);
    if (bus.out_valid && first_ov_e < 0) first_ov_e = ecount;
    last_obs.row  = bus.out_row;
    last_obs.data = bus.out_data;
  endfunction

  task automatic step(input beat_t b, input bit rdy, input bit clr);
    for (int i = N-1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = b;
    bus.in_valid = b.v;
    bus.in_first = b.v ? b.f : 1'($urandom);
    bus.in_last  = b.v ? b.l : 1'($urandom);
    for (int k = 0; k < N; k++)
      bus.psum_in[k*PSB +: PSB] = hist[k].v ? PSB'(hist[k].lane[k]) : PSB'($urandom);
    bus.out_ready = rdy;
    bus.flag_clr  = clr;
    if (b.v && rstn) model_issue(b);
    @(posedge clk);
    if (rstn) model_edge(rdy, clr);
    ecount++;
    @(negedge clk);
    compare();
  endtask

  task automatic drain(input int n);
    int cyc = 0;
    while (got.size() < n && cyc < 60) begin
      step(mk(0, 0, 0, 0, 0), 1'b1, 1'b0);
      cyc++;
    end
    check("drain_count", got.size(), n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    int t0, idx;
    beat_t b;

    checks = 0; errors = 0; ecount = 0; first_ov_e = -1;
    model_reset();
    for (int r = 0; r < ROWS; r++) begin
      skew_tab[r].base = 10 * r;
      skew_tab[r].exp_row = r;
      d = '0;
      for (int k = 0; k < N; k++) d[k*ACC +: ACC] = ACC'(10 * r + k);
      skew_tab[r].exp_data = d;
    end
    pass_tab[0] = '{5, 1'b1, 1'b0, 0};
    pass_tab[1] = '{5, 1'b0, 1'b0, 0};
    pass_tab[2] = '{5, 1'b0, 1'b1, 15};
    pass_tab[3] = '{-7, 1'b1, 1'b1, -7};

    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.psum_in = '0; bus.out_ready = 1'b0; bus.flag_clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_row", bus.out_row, 0);
    check("rst_sat", bus.sat_flag, 0);
    check("rst_ovf", bus.ovf_flag, 0);
    rstn = 1'b1;

    // De-skew and latency
    got.delete();
    t0 = ecount;
    first_ov_e = -1;
    for (int r = 0; r < ROWS; r++) step(mk(1, 1, 1, skew_tab[r].base, 1), 1'b1, 1'b0);
    drain(ROWS);
    check("first_valid_latency", first_ov_e - t0, N + 1);
    for (int r = 0; r < ROWS && r < got.size(); r++) begin
      check("skew_row", got[r].row, skew_tab[r].exp_row);
      check("skew_data", got[r].data, skew_tab[r].exp_data);
    end

    // Multi-pass accumulate then overwrite
    got.delete();
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < ROWS; r++)
        step(mk(1, pass_tab[p].first, pass_tab[p].last, pass_tab[p].val, 0), 1'b1, 1'b0);
    drain(2 * ROWS);
    idx = 0;
    for (int p = 0; p < 4; p++) begin
      if (pass_tab[p].last) begin
        for (int r = 0; r < ROWS; r++) begin
          if (idx < got.size()) begin
            check("pass_row", got[idx].row, r);
            check_lanes("pass_data", got[idx].data, pass_tab[p].exp, 0);
          end
          idx++;
        end
      end
    end

    // Saturation at ACC=20 bits
    got.delete();
    for (int p = 0; p < 4; p++)
      for (int r = 0; r < ROWS; r++)
        step(mk(1, p == 0, 1, 262143, 0), 1'b1, 1'b0);
    drain(4 * ROWS);
    if (got.size() == 4 * ROWS) begin
      check_lanes("sat_pass0", got[0].data, 262143, 0);
      check_lanes("sat_pass1", got[ROWS].data, 524286, 0);
      check_lanes("sat_pass2", got[2*ROWS].data, 524287, 0);
      check_lanes("sat_pass3", got[3*ROWS].data, 524287, 0);
    end
    check("sat_set", bus.sat_flag, 1);
    step(mk(0, 0, 0, 0, 0), 1'b1, 1'b1);
    check("sat_cleared", bus.sat_flag, 0);

    // Full FIFO with simultaneous pop and push
    got.delete();
    t0 = ecount;
    for (int j = 0; j < N + 8; j++) begin
      b = (j < FD + 1) ? mk(1, 1, 1, 200 + 10 * j, 1) : mk(0, 0, 0, 0, 0);
      step(b, ecount == t0 + FD + N, 1'b0);
    end
    check("simul_ovf", bus.ovf_flag, 0);
    check("simul_popped", got.size(), 1);
    drain(FD + 1);
    for (int i = 0; i < FD + 1 && i < got.size(); i++)
      check_lanes("simul_order", got[i].data, 200 + 10 * i, 1);

    // Backpressure overflow on a 6-row last pass
    got.delete();
    for (int r = 0; r < 6; r++) step(mk(1, 1, 1, 100 * r, 1), 1'b0, 1'b0);
    for (int i = 0; i < N + 3; i++) step(mk(0, 0, 0, 0, 0), 1'b0, 1'b0);
    check("ovf_set", bus.ovf_flag, 1);
    check("stall_no_pop", got.size(), 0);
    drain(FD);
    for (int i = 0; i < FD && i < got.size(); i++)
      check_lanes("ovf_kept", got[i].data, 100 * i, 1);
    repeat (3) step(mk(0, 0, 0, 0, 0), 1'b1, 1'b0);
    check("ovf_dropped", got.size(), FD);

    // Async reset with a pass in flight
    for (int r = 0; r < 2; r++) step(mk(1, 1, 1, 50 + r, 1), 1'b1, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_ovf", bus.ovf_flag, 0);
    check("arst_sat", bus.sat_flag, 0);
    model_reset();
    got.delete();
    repeat (2) step(mk(0, 0, 0, 0, 0), 1'b1, 1'b0);
    rstn = 1'b1;
    for (int r = 0; r < ROWS; r++) step(mk(1, 1, 1, 3, 0), 1'b1, 1'b0);
    drain(ROWS);
    repeat (N + 2) step(mk(0, 0, 0, 0, 0), 1'b1, 1'b0);
    check("arst_no_stale", got.size(), ROWS);
    if (got.size() > 0) begin
      check("arst_row0", got[0].row, 0);
      check_lanes("arst_data", got[0].data, 3, 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      b = mk($urandom_range(3, 0) != 0, $urandom_range(3, 0) == 0, $urandom_range(1, 0), 0, 0);
      for (int k = 0; k < N; k++) b.lane[k] = int'($urandom_range(262143 * 2 + 1, 0)) - 262144;
      step(b, $urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0);
    end
    for (int i = 0; i < 40 && (mq.size() > 0 || pend.size() > 0); i++)
      step(mk(0, 0, 0, 0, 0), 1'b1, 1'b0);
    check("final_empty", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
